// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data SRAM port arbiter: FSM encoding and
// the last-grant markers used by the alternating-priority rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, freeze outputs and SRAM handshake.
// The slave modport is the arbiter; the master modport is the pipeline plus SRAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: sram_req holds with stable addr/we/wdata until sram_ready is
    // sampled high on a rising edge; if_valid/dm_valid are one-cycle pulses.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    logic              freeze_if;
    logic              freeze_pipe;

    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ready;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid,
        input  dm_rd, dm_wr, dm_addr, dm_wdata,
        output dm_rdata, dm_valid,
        output freeze_if, freeze_pipe,
        output sram_req, sram_we, sram_addr, sram_wdata,
        input  sram_rdata, sram_ready
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid,
        output dm_rd, dm_wr, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid,
        input  freeze_if, freeze_pipe,
        input  sram_req, sram_we, sram_addr, sram_wdata,
        output sram_rdata, sram_ready
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between fetch and data stages, one access at a
// time, with alternating priority on contention and pipeline freeze generation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    mem_port_arbiter_if.slave bus,
    output state_t dbg_state
);

    state_t            state;
    state_t            state_n;
    logic              last_grant;
    logic              serving;
    logic              dropped;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              grant;
    logic              grant_dm;
    logic              dm_pending;
    logic              if_valid_w;
    logic              dm_valid_w;
    logic              freeze_pipe_w;

    assign dm_pending = bus.dm_rd | bus.dm_wr;

    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        grant_dm = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dm_pending || bus.if_req) begin
                    grant    = 1'b1;
                    // On contention the port that lost last time wins now.
                    grant_dm = dm_pending && (!bus.if_req || last_grant == GRANT_IF);
                    state_n  = grant_dm ? ST_DATA : ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (bus.sram_ready) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_IF;
            serving    <= GRANT_IF;
            dropped    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                last_grant <= grant_dm ? GRANT_DM : GRANT_IF;
                serving    <= grant_dm ? GRANT_DM : GRANT_IF;
                dropped    <= 1'b0;
                addr_q     <= grant_dm ? bus.dm_addr : bus.if_addr;
                we_q       <= grant_dm & bus.dm_wr;
                wdata_q    <= bus.dm_wdata;
            end
            // A flushed fetch still runs to completion on the SRAM side.
            if (state == ST_FETCH && bus.if_flush) begin
                dropped <= 1'b1;
            end
            if (state == ST_FETCH && bus.sram_ready) begin
                if_rdata_q <= bus.sram_rdata;
            end
            if (state == ST_DATA && bus.sram_ready && !we_q) begin
                dm_rdata_q <= bus.sram_rdata;
            end
        end
    end

    assign if_valid_w    = (state == ST_RESP) && (serving == GRANT_IF) && !dropped && !bus.if_flush;
    assign dm_valid_w    = (state == ST_RESP) && (serving == GRANT_DM);
    assign freeze_pipe_w = dm_pending & ~dm_valid_w;

    assign bus.if_valid    = if_valid_w;
    assign bus.dm_valid    = dm_valid_w;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.freeze_pipe = freeze_pipe_w;
    assign bus.freeze_if   = freeze_pipe_w | (bus.if_req & ~if_valid_w);
    assign bus.sram_req    = (state == ST_FETCH) || (state == ST_DATA);
    assign bus.sram_we     = we_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_wdata  = wdata_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: SRAM responder, scoreboard of expected completions
// and SRAM accesses, directed timing cases and randomized request rounds.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: word memory, alternating-priority bookkeeping, queues.
    logic [31:0] ref_mem [int];
    logic [31:0] sram_mem [int];
    logic        model_last;
    logic [31:0] model_dm_rdata;
    logic [32:0] exp_q [$];
    logic [64:0] acc_q [$];
    int          fixed_waits;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : init_word(widx(a));
    endfunction

    task automatic model_reset();
        model_last     = GRANT_IF;
        model_dm_rdata = 32'h0;
    endtask

    task automatic model_fetch(input logic [31:0] a, input bit completes);
        acc_q.push_back({1'b0, a, 32'h0});
        if (completes) exp_q.push_back({1'b0, ref_read(a)});
        model_last = GRANT_IF;
    endtask

    task automatic model_data(input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (wr) begin
            acc_q.push_back({1'b1, a, d});
            ref_mem[widx(a)] = d;
        end else begin
            acc_q.push_back({1'b0, a, 32'h0});
            model_dm_rdata = ref_read(a);
        end
        exp_q.push_back({1'b1, model_dm_rdata});
        model_last = GRANT_DM;
    endtask

    // Monitor (completion scoreboard) and SRAM responder, both away from the active edge.
    bit          in_acc = 1'b0;
    int          waits_left;
    logic [64:0] cur_acc;
    logic [64:0] exp_acc;
    logic [32:0] exp_resp;

    always @(negedge clk) begin
        if (!rst && (bus.if_valid || bus.dm_valid)) begin
            if (bus.if_valid && bus.dm_valid) check("dual_valid", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {bus.dm_valid, bus.if_valid}, 0);
            end else begin
                exp_resp = exp_q.pop_front();
                check("resp_port", bus.dm_valid, exp_resp[32]);
                check("resp_data", bus.dm_valid ? bus.dm_rdata : bus.if_rdata, exp_resp[31:0]);
            end
        end

        if (rst || !bus.sram_req) begin
            in_acc         = 1'b0;
            bus.sram_ready = 1'b0;
            bus.sram_rdata = 32'h0;
        end else begin
            if (!in_acc) begin
                in_acc     = 1'b1;
                waits_left = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 3));
                cur_acc    = {bus.sram_we, bus.sram_addr, bus.sram_wdata};
                if (acc_q.size() == 0) begin
                    check("unexpected_sram_req", 1, 0);
                end else begin
                    exp_acc = acc_q.pop_front();
                    check("sram_we", bus.sram_we, exp_acc[64]);
                    check("sram_addr", bus.sram_addr, exp_acc[63:32]);
                    if (exp_acc[64]) check("sram_wdata", bus.sram_wdata, exp_acc[31:0]);
                end
            end else begin
                check("sram_hold", {bus.sram_we, bus.sram_addr, bus.sram_wdata}, cur_acc);
            end
            if (waits_left == 0) begin
                bus.sram_ready = 1'b1;
                bus.sram_rdata = sram_mem.exists(widx(bus.sram_addr)) ?
                                 sram_mem[widx(bus.sram_addr)] : init_word(widx(bus.sram_addr));
                if (bus.sram_we) sram_mem[widx(bus.sram_addr)] = bus.sram_wdata;
            end else begin
                waits_left--;
                bus.sram_ready = 1'b0;
                bus.sram_rdata = $urandom;
            end
        end
    end

    task automatic clear_reqs();
        bus.if_req = 1'b0;
        bus.dm_rd  = 1'b0;
        bus.dm_wr  = 1'b0;
    endtask

    // Single access with a fixed number of wait states; checks cycle-exact timing.
    task automatic latency_case(input bit is_fetch, input bit rd, input bit wr,
                                input logic [31:0] a, input logic [31:0] d, input int waits);
        int vk = -1;
        int first_req = -1;
        int req_cnt = 0;
        bit frz_ok = 1'b1;
        fixed_waits = waits;
        @(posedge clk); #1;
        if (is_fetch) begin
            bus.if_req = 1'b1; bus.if_addr = a;
            model_fetch(a, 1'b1);
        end else begin
            bus.dm_rd = rd; bus.dm_wr = wr; bus.dm_addr = a; bus.dm_wdata = d;
            model_data(wr, a, d);
        end
        for (int k = 0; k < 20 && vk < 0; k++) begin
            @(negedge clk);
            if (bus.sram_req) begin
                req_cnt++;
                if (first_req < 0) first_req = k;
            end
            if (bus.if_valid || bus.dm_valid) begin
                vk = k;
                check("freeze_if_at_valid", bus.freeze_if, 0);
                check("freeze_pipe_at_valid", bus.freeze_pipe, 0);
            end else if (!bus.freeze_if || (bus.freeze_pipe == is_fetch)) begin
                frz_ok = 1'b0;
            end
        end
        check("first_req_cycle", first_req, 1);
        check("req_cycles", req_cnt, waits + 1);
        check("valid_cycle", vk, waits + 2);
        check("freeze_before_valid", frz_ok, 1);
        @(posedge clk); #1;
        clear_reqs();
        fixed_waits = -1;
    endtask

    task automatic contention_test();
        logic [31:0] a, b, d;
        int n_got = 0;
        bit ord [4];
        a = rand_addr(); b = rand_addr() ^ 32'h200; d = $urandom;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = a;
        bus.dm_wr = 1'b1; bus.dm_addr = b; bus.dm_wdata = d;
        model_reset();
        model_data(1'b1, b, d); model_fetch(a, 1'b1);
        model_data(1'b1, b, d); model_fetch(a, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 100 && n_got < 4; n++) begin
            @(negedge clk);
            if (bus.dm_valid || bus.if_valid) begin
                ord[n_got] = bus.dm_valid;
                n_got++;
            end
        end
        @(posedge clk); #1;
        clear_reqs();
        check("contention_count", n_got, 4);
        for (int i = 0; i < 4; i++) check("contention_order", ord[i], (i % 2 == 0) ? 1 : 0);
    endtask

    task automatic flush_test();
        logic [31:0] a, b;
        int vk = -1;
        bit saw_idle = 1'b0;
        a = rand_addr(); b = rand_addr() ^ 32'h300;
        fixed_waits = 2;
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = a;
        model_fetch(a, 1'b0);
        model_fetch(b, 1'b1);
        @(posedge clk); #1;
        bus.if_flush = 1'b1; bus.if_addr = b;
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        for (int k = 2; k < 40 && vk < 0; k++) begin
            @(negedge clk);
            if (bus.if_valid) vk = k;
            if (dbg_state == ST_IDLE) saw_idle = 1'b1;
        end
        check("flush_refetch_cycle", vk, 9);
        check("flush_saw_idle", saw_idle, 1);
        @(posedge clk); #1;
        clear_reqs();
        fixed_waits = -1;
    endtask

    task automatic reset_data_test();
        logic [31:0] a;
        bit got = 1'b0;
        a = rand_addr();
        fixed_waits = 10;
        @(posedge clk); #1;
        bus.dm_rd = 1'b1; bus.dm_addr = a;
        acc_q.push_back({1'b0, a, 32'h0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fixed_waits = 0;
        model_reset();
        model_data(1'b0, a, 32'h0);
        @(negedge clk);
        check("rst_mid_sram_req", bus.sram_req, 0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        check("rst_mid_dm_valid", bus.dm_valid, 0);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.dm_valid) got = 1'b1;
        end
        check("rst_regrant_done", got, 1);
        @(posedge clk); #1;
        clear_reqs();
        fixed_waits = -1;
    endtask

    task automatic random_round();
        int kind;
        bit want_if, want_dm, rd, wr, got_if, got_dm;
        logic [31:0] ia, da, dd;
        kind    = $urandom_range(0, 5);
        want_if = (kind == 0) || (kind >= 3);
        want_dm = (kind != 0);
        rd      = (kind == 1) || (kind == 3) || (kind == 5);
        wr      = (kind == 2) || (kind == 4) || (kind == 5);
        ia = rand_addr(); da = rand_addr(); dd = $urandom;
        if (want_if && want_dm) begin
            if (model_last == GRANT_IF) begin
                model_data(wr, da, dd); model_fetch(ia, 1'b1);
            end else begin
                model_fetch(ia, 1'b1); model_data(wr, da, dd);
            end
        end else if (want_if) begin
            model_fetch(ia, 1'b1);
        end else begin
            model_data(wr, da, dd);
        end
        @(posedge clk); #1;
        bus.if_req = want_if; bus.if_addr = ia;
        bus.dm_rd = want_dm & rd; bus.dm_wr = want_dm & wr;
        bus.dm_addr = da; bus.dm_wdata = dd;
        got_if = !want_if;
        got_dm = !want_dm;
        for (int n = 0; n < 100 && !(got_if && got_dm); n++) begin
            @(negedge clk);
            if (bus.if_valid) got_if = 1'b1;
            if (bus.dm_valid) got_dm = 1'b1;
            @(posedge clk); #1;
            if (got_if) bus.if_req = 1'b0;
            if (got_dm) begin bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; end
        end
        check("round_done", {got_if, got_dm}, 2'b11);
        clear_reqs();
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        fixed_waits = -1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_sram_req", bus.sram_req, 0);
        check("reset_sram_we", bus.sram_we, 0);
        check("reset_sram_addr", bus.sram_addr, 0);
        check("reset_if_valid", bus.if_valid, 0);
        check("reset_dm_valid", bus.dm_valid, 0);
        check("reset_if_rdata", bus.if_rdata, 0);
        check("reset_dm_rdata", bus.dm_rdata, 0);
        check("reset_freeze_if", bus.freeze_if, 0);
        check("reset_freeze_pipe", bus.freeze_pipe, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        latency_case(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1);
        latency_case(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 3);
        latency_case(1'b0, 1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 0);
        latency_case(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 2);
        contention_test();
        flush_test();
        reset_data_test();
        repeat (40) random_round();

        repeat (3) @(posedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("acc_q_empty", acc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
